// File: rtl/y86_bus_if.sv
// Core-side bus of the y86 sequential core: byte address, store data,
// load data and the two strobes. The core is the master; the memory-side
// responder is the slave.
interface y86_bus_if;
  logic [31:0] bus_A;
  logic [31:0] bus_out;
  logic        bus_WE;
  logic        bus_RE;
  logic [31:0] bus_in;

  modport master (
    output bus_A,
    output bus_out,
    output bus_WE,
    output bus_RE,
    input  bus_in
  );

  modport slave (
    input  bus_A,
    input  bus_out,
    input  bus_WE,
    input  bus_RE,
    output bus_in
  );
endinterface

// File: rtl/y86_bus_responder.sv
// Memory-side responder for the y86 core bus.
// - Byte RAM with 32-bit little-endian reads and writes. Indices wrap
//   modulo DEPTH, and the read path is combinational.
// - LOAD state streams program bytes into RAM while the core is held in reset.
// - Stores to CON_ADDR push into a console FIFO. Reads of CON_ADDR return
//   the FIFO status.
// - Optional macro Y86_BUS_STATS_EN adds the stat_rd/stat_wr access counters,
//   readable at CON_ADDR+4 and CON_ADDR+8.
module y86_bus_responder #(
  parameter int          ADDR_W     = 12,
  parameter logic [31:0] CON_ADDR   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  y86_bus_if.slave    bus,
  output logic        cpu_rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        ld_done,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        con_ovf,
`ifdef Y86_BUS_STATS_EN
  output logic [31:0] stat_rd,
  output logic [31:0] stat_wr,
`endif
  output logic        bus_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = $clog2(FIFO_DEPTH);

  typedef enum logic {LOAD, RUN} state_t;

  state_t state, state_nxt;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] ld_ptr;
  logic [ADDR_W-1:0] a0, a1, a2, a3;

  logic              in_range, is_con, run;
  logic [31:0]       rd_data;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       count;
  logic              full, empty, push_req, push, pop;

`ifdef Y86_BUS_STATS_EN
  logic              is_stat_rd, is_stat_wr;
`endif

  // State register; only rst_n brings the FSM back to LOAD
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next state: leave LOAD once ld_done is sampled, then stay in RUN
  always_comb begin
    state_nxt = state;
    if (state == LOAD && ld_done) state_nxt = RUN;
  end

  // Outputs decoded from state: the core is held in reset and the loader is accepted while loading
  always_comb begin
    cpu_rst  = (state == LOAD);
    ld_ready = (state == LOAD);
    run      = (state == RUN);
  end

  // Address decode and the four wrapped byte indices of the word access
  always_comb begin
    in_range = (bus.bus_A[31:ADDR_W] == '0);
    is_con   = (bus.bus_A == CON_ADDR);
`ifdef Y86_BUS_STATS_EN
    is_stat_rd = (bus.bus_A == CON_ADDR + 32'd4);
    is_stat_wr = (bus.bus_A == CON_ADDR + 32'd8);
`endif
    a0 = bus.bus_A[ADDR_W-1:0];
    a1 = a0 + ADDR_W'(1);
    a2 = a0 + ADDR_W'(2);
    a3 = a0 + ADDR_W'(3);
  end

  // Zero-latency read mux, since the core samples bus_in in the same cycle
  always_comb begin
    rd_data = '0;
    if (in_range)
      rd_data = {mem[a3], mem[a2], mem[a1], mem[a0]};
    else if (is_con)
      rd_data = {16'b0, 8'(count), 6'b0, full, empty};
`ifdef Y86_BUS_STATS_EN
    else if (is_stat_rd)
      rd_data = stat_rd;
    else if (is_stat_wr)
      rd_data = stat_wr;
`endif
    bus.bus_in = rd_data;
  end

  // The loader pointer advances on each accepted byte and wraps at the top of RAM
  always_ff @(posedge clk) begin
    if (!rst_n)                        ld_ptr <= '0;
    else if (state == LOAD && ld_valid) ld_ptr <= ld_ptr + ADDR_W'(1);
  end

  // RAM writes come from the loader in LOAD and from in-range core stores in RUN; RAM is not reset
  always_ff @(posedge clk) begin
    if (run) begin
      if (bus.bus_WE && in_range) begin
        mem[a0] <= bus.bus_out[7:0];
        mem[a1] <= bus.bus_out[15:8];
        mem[a2] <= bus.bus_out[23:16];
        mem[a3] <= bus.bus_out[31:24];
      end
    end else if (ld_valid) begin
      mem[ld_ptr] <= ld_data;
    end
  end

  // Console FIFO handshake. A push into a full FIFO is allowed only when a pop frees a slot this cycle
  always_comb begin
    empty     = (count == '0);
    full      = (count == (PW+1)'(FIFO_DEPTH));
    con_valid = !empty;
    con_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    pop       = con_valid && con_ready;
    push_req  = run && bus.bus_WE && is_con;
    push      = push_req && (!full || pop);
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; only the slot being pushed changes
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.bus_out[7:0];
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      con_ovf <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (push_req && full && !pop) con_ovf <= 1'b1;
      if (run && bus.bus_WE && !in_range && !is_con) bus_err <= 1'b1;
`ifdef Y86_BUS_STATS_EN
      if (run && bus.bus_RE && !in_range && !is_con && !is_stat_rd && !is_stat_wr)
        bus_err <= 1'b1;
`else
      if (run && bus.bus_RE && !in_range && !is_con) bus_err <= 1'b1;
`endif
    end
  end

`ifdef Y86_BUS_STATS_EN
  // Saturating counters of RUN cycles that carry a read or write strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else if (run) begin
      if (bus.bus_RE && stat_rd != 32'hFFFF_FFFF) stat_rd <= stat_rd + 32'd1;
      if (bus.bus_WE && stat_wr != 32'hFFFF_FFFF) stat_wr <= stat_wr + 32'd1;
    end
  end
`endif

endmodule
